conv_operand_loader: RTL and testbench

Sequential front end for the combinational convolution core. Accepts a byte stream over a valid/ready handshake and assembles the 200-bit kernel and pixel operand buses in the core's row-major 5-column layout. Holds the buses stable for one evaluation cycle, captures the core's 16-bit result, and returns it over a second valid/ready handshake. Sits between the coprocessor's data-fetch path and the convolution core.

---
 rtl/conv_operand_loader.sv | 154 +++++++++++++++
 tb/tb_conv_operand_loader.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/conv_operand_loader.sv
// conv_operand_loader: byte-stream front end for the combinational convolution core.
// Collects n*n kernel bytes then n*n pixel bytes (row-major, row stride MAX_DIM)
// into two operand buses, holds them for one evaluation cycle, captures the core
// result and returns it over a valid/ready handshake.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   cfg_size, start     matrix size code (n = cfg_size+2), begin a load (IDLE only)
//   in_data/valid/ready operand byte stream, kernel bytes first then pixel bytes
//   kernel_bus          signed kernel operand to the core
//   pixel_bus           unsigned pixel operand to the core
//   size_out            latched size code for the core
//   conv_result         core result
//   res_data/valid/ready captured result handshake
//   busy                high whenever the loader is not idle
//
// Optional build macro CONV_RES_CLAMP_EN: clamps the captured result to the
// pixel range [0, 2**DATA_W-1]; otherwise the raw signed result is captured.

module conv_operand_loader #(
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned MAX_DIM = 5,
   parameter int unsigned BUS_W   = MAX_DIM * MAX_DIM * DATA_W,
   parameter int unsigned RES_W   = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [1:0]        cfg_size,
   input  logic              start,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [BUS_W-1:0]  kernel_bus,
   output logic [BUS_W-1:0]  pixel_bus,
   output logic [1:0]        size_out,
   input  logic [RES_W-1:0]  conv_result,
   output logic [RES_W-1:0]  res_data,
   output logic              res_valid,
   input  logic              res_ready,
   output logic              busy
);

   localparam int unsigned CNT_W = 3;
   localparam int unsigned IDX_W = $clog2(BUS_W);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD_K = 3'd1,
      LOAD_P = 3'd2,
      EVAL   = 3'd3,
      OUT    = 3'd4
   } state_t;

   state_t             state;
   logic [CNT_W-1:0]   row;
   logic [CNT_W-1:0]   col;
   logic [CNT_W-1:0]   dim_last_c;
   logic [IDX_W-1:0]   bit_idx_c;
   logic [RES_W-1:0]   capture_c;
   logic               accept_c;

   // Last row/col index is n-1 = size code + 1.
   assign dim_last_c = CNT_W'({1'b0, size_out}) + CNT_W'(1);
   // Bit offset of element (row,col) in the fixed 5-column layout.
   assign bit_idx_c  = IDX_W'((32'(row) * MAX_DIM + 32'(col)) * DATA_W);
   assign accept_c   = in_valid && in_ready;

   // Value registered at the end of EVAL.
   always_comb begin
      capture_c = conv_result;
`ifdef CONV_RES_CLAMP_EN
      if (conv_result[RES_W-1]) begin
         capture_c = '0;
      end else if (conv_result > RES_W'((1 << DATA_W) - 1)) begin
         capture_c = RES_W'((1 << DATA_W) - 1);
      end
`endif
   end

   // Control FSM with registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         row        <= '0;
         col        <= '0;
         kernel_bus <= '0;
         pixel_bus  <= '0;
         size_out   <= '0;
         res_data   <= '0;
         in_ready   <= 1'b0;
         res_valid  <= 1'b0;
         busy       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  size_out   <= cfg_size;
                  kernel_bus <= '0;
                  pixel_bus  <= '0;
                  row        <= '0;
                  col        <= '0;
                  in_ready   <= 1'b1;
                  busy       <= 1'b1;
                  state      <= LOAD_K;
               end
            end
            LOAD_K, LOAD_P: begin
               if (accept_c) begin
                  if (state == LOAD_K) begin
                     kernel_bus[bit_idx_c +: DATA_W] <= in_data;
                  end else begin
                     pixel_bus[bit_idx_c +: DATA_W] <= in_data;
                  end
                  if (col == dim_last_c) begin
                     col <= '0;
                     if (row == dim_last_c) begin
                        row <= '0;
                        if (state == LOAD_K) begin
                           state <= LOAD_P;
                        end else begin
                           in_ready <= 1'b0;
                           state    <= EVAL;
                        end
                     end else begin
                        row <= row + CNT_W'(1);
                     end
                  end else begin
                     col <= col + CNT_W'(1);
                  end
               end
            end
            EVAL: begin
               res_data  <= capture_c;
               res_valid <= 1'b1;
               state     <= OUT;
            end
            OUT: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               in_ready  <= 1'b0;
               res_valid <= 1'b0;
               busy      <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_conv_operand_loader.sv
// Testbench for conv_operand_loader: behavioural convolution core, table of
// transactions, result scoreboard, plus reset-during-load sequence.

module tb_conv_operand_loader;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [1:0]   cfg_size = 2'd0;
   logic         start = 1'b0;
   logic [7:0]   in_data = 8'd0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [199:0] kernel_bus;
   logic [199:0] pixel_bus;
   logic [1:0]   size_out;
   logic [15:0]  conv_result;
   logic [15:0]  res_data;
   logic         res_valid;
   logic         res_ready = 1'b0;
   logic         busy;

   int errors = 0;
   int checks = 0;
   logic [15:0] sb_q[$];
   int core_acc;

   conv_operand_loader dut (
      .clk(clk), .rst_n(rst_n), .cfg_size(cfg_size), .start(start),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .kernel_bus(kernel_bus), .pixel_bus(pixel_bus), .size_out(size_out),
      .conv_result(conv_result), .res_data(res_data), .res_valid(res_valid),
      .res_ready(res_ready), .busy(busy)
   );

   always #5 clk = ~clk;

   // Combinational core model: signed kernel bytes times unsigned pixel bytes.
   always_comb begin
      core_acc = 0;
      for (int i = 0; i < 25; i++)
         core_acc += int'($signed(kernel_bus[i*8 +: 8])) * int'(pixel_bus[i*8 +: 8]);
   end
   assign conv_result = 16'(core_acc);

   typedef struct {
      logic [1:0]  size;
      logic [7:0]  kbase, kstep, pbase, pstep;
      logic [15:0] exp_res;
      bit          toggle;
      bit          glitch;
      int          hold;
   } vec_t;

   vec_t vecs[5];

   task automatic check(input string name, input logic [199:0] got, input logic [199:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timeout waiting for DUT", name);
   endtask

   function automatic logic [7:0] elem(input logic [7:0] base, input logic [7:0] step, input int i);
      return 8'(int'(base) + int'(step) * i);
   endfunction

   function automatic logic [199:0] build_bus(input int n, input logic [7:0] base, input logic [7:0] step);
      logic [199:0] b = '0;
      for (int r = 0; r < n; r++)
         for (int c = 0; c < n; c++)
            b[(r*5 + c)*8 +: 8] = elem(base, step, r*n + c);
      return b;
   endfunction

   function automatic logic [7:0] stream_byte(input vec_t v, input int n, input int idx);
      if (idx < n*n) return elem(v.kbase, v.kstep, idx);
      return elem(v.pbase, v.pstep, idx - n*n);
   endfunction

   // Full transaction; called at #1 after a rising edge.
   task automatic run_txn(input vec_t v, input string tag);
      int n = int'(v.size) + 2;
      int total = 2*n*n;
      int idx = 0;
      int cyc;
      int guard = 0;
      bit acc;
      bit glitched = 0;
      cfg_size = v.size;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cfg_size = ~v.size;
      sb_q.push_back(v.exp_res);
      cyc = 1;
      check({tag, " busy_after_start"}, 200'(busy), 200'(1));
      while (idx < total && guard < 2000) begin
         in_valid = v.toggle ? (cyc % 2 == 0) : 1'b1;
         in_data  = in_valid ? stream_byte(v, n, idx) : 8'hA5;
         if (v.glitch && !glitched && idx == 2) begin
            start = 1'b1;
            glitched = 1;
         end
         acc = in_valid && in_ready;
         @(posedge clk); #1;
         start = 1'b0;
         if (acc) idx++;
         cyc++;
         guard++;
      end
      in_valid = 1'b0;
      if (idx < total) timeout({tag, " load"});
      guard = 0;
      while (!res_valid && guard < 50) begin
         @(posedge clk); #1;
         cyc++;
         guard++;
      end
      if (!res_valid) timeout({tag, " res_valid"});
      if (!v.toggle) check({tag, " latency"}, 200'(cyc), 200'(2*n*n + 2));
      check({tag, " kernel_bus"}, kernel_bus, build_bus(n, v.kbase, v.kstep));
      check({tag, " pixel_bus"}, pixel_bus, build_bus(n, v.pbase, v.pstep));
      check({tag, " size_out"}, 200'(size_out), 200'(v.size));
      check({tag, " in_ready_low"}, 200'(in_ready), 200'(0));
      for (int h = 0; h < v.hold; h++) begin
         @(posedge clk); #1;
         check({tag, " hold_valid"}, 200'(res_valid), 200'(1));
         check({tag, " hold_data"}, 200'(res_data), 200'(v.exp_res));
      end
      res_ready = 1'b1;
      acc = res_valid && res_ready;
      if (acc) begin
         if (sb_q.size() == 0) timeout({tag, " scoreboard_empty"});
         else check({tag, " res_data"}, 200'(res_data), 200'(sb_q.pop_front()));
      end
      @(posedge clk); #1;
      res_ready = 1'b0;
      check({tag, " res_valid_drop"}, 200'(res_valid), 200'(0));
      check({tag, " busy_idle"}, 200'(busy), 200'(0));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " kernel_bus"}, kernel_bus, '0);
      check({tag, " pixel_bus"}, pixel_bus, '0);
      check({tag, " size_out"}, 200'(size_out), '0);
      check({tag, " res_data"}, 200'(res_data), '0);
      check({tag, " in_ready"}, 200'(in_ready), '0);
      check({tag, " res_valid"}, 200'(res_valid), '0);
      check({tag, " busy"}, 200'(busy), '0);
   endtask

   initial begin
      // size, kbase, kstep, pbase, pstep, expected result, toggle, glitch, hold
      vecs[0] = '{2'd0, 8'd1,    8'd0, 8'd10, 8'd10,  16'd100, 0, 0, 0};
`ifdef CONV_RES_CLAMP_EN
      vecs[1] = '{2'd1, 8'd1,    8'd1, 8'd15, 8'hFF,  16'd255, 1, 0, 0};
      vecs[3] = '{2'd0, 8'hFF,   8'd0, 8'd10, 8'd0,   16'h0000, 0, 0, 0};
      vecs[4] = '{2'd1, 8'd1,    8'd1, 8'd15, 8'hFF,  16'd255, 0, 1, 0};
`else
      vecs[1] = '{2'd1, 8'd1,    8'd1, 8'd15, 8'hFF,  16'd435, 1, 0, 0};
      vecs[3] = '{2'd0, 8'hFF,   8'd0, 8'd10, 8'd0,   16'hFFD8, 0, 0, 0};
      vecs[4] = '{2'd1, 8'd1,    8'd1, 8'd15, 8'hFF,  16'd435, 0, 1, 0};
`endif
      vecs[2] = '{2'd3, 8'd1,    8'd0, 8'd5,  8'd0,   16'd125, 0, 0, 3};

      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 5; i++)
         run_txn(vecs[i], $sformatf("vec%0d", i));

      // Reset in the middle of the pixel load.
      cfg_size = 2'd1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 12; i++) begin
         in_valid = 1'b1;
         in_data = 8'(i + 3);
         @(posedge clk); #1;
      end
      check("midload busy", 200'(busy), 200'(1));
      in_valid = 1'b0;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      check_reset_outputs("midload_reset");
      run_txn(vecs[0], "after_reset");

      check("scoreboard_drained", 200'(sb_q.size()), 200'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
